// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifu_pkg;

  // Instruction field positions
  localparam int unsigned OP7_MSB = 15;
  localparam int unsigned OP7_LSB = 9;
  localparam int unsigned OP6_MSB = 15;
  localparam int unsigned OP6_LSB = 10;
  localparam int unsigned LIT_MSB = 7;
  localparam int unsigned LIT_LSB = 0;

  // Control-flow opcodes
  localparam logic [6:0] OP_CALL  = 7'b1001110;
  localparam logic [6:0] OP_RET   = 7'b1001111;
  localparam logic [6:0] OP_JUMPR = 7'b1001101;
  localparam logic [5:0] OP_BRZ   = 6'b101101;
  localparam logic [5:0] OP_BRN   = 6'b101110;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FULL,
    S_FAULT
  } ifu_state_e;

endpackage

// File: rtl/return_addr_stack.sv
// Return-address stack: DEPTH entries of WIDTH bits with occupancy count.
// The caller never issues push and pop together, nor push when full / pop when empty.
module return_addr_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    if (push_i && !full_o) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push_i && !full_o && count_q == CNT_W'(i)) begin
        mem_q[i] <= push_data_i;
      end
    end
  end

  // Top of stack is the entry just below the count
  always_comb begin
    top_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (count_q == CNT_W'(i + 1)) begin
        top_o = mem_q[i];
      end
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the ROM address, holds one instruction for decode and
// resolves CALL/RET/JUMPR/BRZ/BRN locally using a return-address stack.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [INSTR_W-1:0]             rom_data,
  output logic [INSTR_W-1:0]             instr,
  output logic [ADDR_W-1:0]              instr_pc,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  input  logic                           z_flag,
  input  logic                           n_flag,
  input  logic [ADDR_W-1:0]              reg_target,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           fault
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  ifu_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                fault_q, fault_d;

  logic [6:0]          op7;
  logic [5:0]          op6;
  logic [ADDR_W-1:0]   lit, pc_inc, next_pc;
  logic                is_call, is_ret, is_jumpr, is_brz, is_brn;
  logic                handoff, ras_err, ras_push, ras_pop;
  logic [ADDR_W-1:0]   ras_top;
  logic                ras_full, ras_empty;

  assign op7 = instr_q[OP7_MSB:OP7_LSB];
  assign op6 = instr_q[OP6_MSB:OP6_LSB];
  assign lit = ADDR_W'(instr_q[LIT_MSB:LIT_LSB]);

  assign is_call  = (op7 == OP_CALL);
  assign is_ret   = (op7 == OP_RET);
  assign is_jumpr = (op7 == OP_JUMPR);
  assign is_brz   = (op6 == OP_BRZ);
  assign is_brn   = (op6 == OP_BRN);

  assign pc_inc = instr_pc_q + ADDR_W'(1);

  // Next-PC selection for the held instruction
  always_comb begin
    next_pc = pc_inc;
    if (is_call) begin
      next_pc = lit;
    end else if (is_ret) begin
      next_pc = ras_top;
    end else if (is_jumpr) begin
      next_pc = reg_target;
    end else if (is_brz) begin
      next_pc = z_flag ? lit : pc_inc;
    end else if (is_brn) begin
      next_pc = n_flag ? lit : pc_inc;
    end
  end

  assign handoff  = (state_q == S_FULL) && instr_ready;
  // Stack overflow/underflow: the instruction still goes out but the stack is untouched
  assign ras_err  = (is_call && ras_full) || (is_ret && ras_empty);
  assign ras_push = handoff && is_call && !ras_full;
  assign ras_pop  = handoff && is_ret && !ras_empty;

  return_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W),
    .CNT_W (CNT_W)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_inc),
    .top_o       (ras_top),
    .count_o     (ras_count),
    .full_o      (ras_full),
    .empty_o     (ras_empty)
  );

  // FSM next-state, ROM address and holding-register updates
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    fault_d     = fault_q;
    rom_addr    = fetch_pc_q;
    instr_valid = 1'b0;
    case (state_q)
      S_EMPTY: begin
        rom_addr = fetch_pc_q;
        if (run) begin
          instr_d    = rom_data;
          instr_pc_d = fetch_pc_q;
          state_d    = S_FULL;
        end
      end
      S_FULL: begin
        instr_valid = 1'b1;
        rom_addr    = next_pc;
        if (handoff) begin
          if (ras_err) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            instr_d    = rom_data;
            instr_pc_d = next_pc;
          end
        end
      end
      S_FAULT: begin
        rom_addr = instr_pc_q;
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // State and holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      fetch_pc_q <= ADDR_W'(RESET_PC);
      instr_q    <= '0;
      instr_pc_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_q;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      fault_q    <= fault_d;
    end
  end

  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural combinational ROM.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        z_flag;
  logic        n_flag;
  logic [7:0]  reg_target;
  logic [2:0]  ras_count;
  logic        fault;

  logic [15:0] rom [256];
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  instr_fetch_unit #(
    .ADDR_W    (8),
    .INSTR_W   (16),
    .RAS_DEPTH (4),
    .RESET_PC  (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .z_flag      (z_flag),
    .n_flag      (n_flag),
    .reg_target  (reg_target),
    .ras_count   (ras_count),
    .fault       (fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_held(input string tag, input logic [7:0] pc, input logic [15:0] ins);
    check_eq({tag, " valid"}, 32'(instr_valid), 32'd1);
    check_eq({tag, " pc"}, 32'(instr_pc), 32'(pc));
    check_eq({tag, " instr"}, 32'(instr), 32'(ins));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] plain(input logic [7:0] a);
    return {8'h10, a};
  endfunction
  function automatic logic [15:0] enc_call(input logic [7:0] a);
    return {7'b1001110, 1'b0, a};
  endfunction
  function automatic logic [15:0] enc_brz(input logic [7:0] a);
    return {6'b101101, 2'b00, a};
  endfunction
  function automatic logic [15:0] enc_brn(input logic [7:0] a);
    return {6'b101110, 2'b00, a};
  endfunction
  localparam logic [15:0] EncRet   = 16'h9E00;
  localparam logic [15:0] EncJumpr = 16'h9A00;

  // Hold the DUT in reset and refill the ROM with plain instructions
  task automatic apply_reset();
    rst_n       = 1'b0;
    run         = 1'b0;
    instr_ready = 1'b0;
    z_flag      = 1'b0;
    n_flag      = 1'b0;
    reg_target  = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = plain(8'(i));
    step();
  endtask

  // Release reset with run/ready high; returns with the first instruction held
  task automatic launch();
    rst_n       = 1'b1;
    run         = 1'b1;
    instr_ready = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    apply_reset();
    check_eq("rst valid", 32'(instr_valid), 32'd0);
    check_eq("rst instr", 32'(instr), 32'd0);
    check_eq("rst pc", 32'(instr_pc), 32'd0);
    check_eq("rst ras", 32'(ras_count), 32'd0);
    check_eq("rst fault", 32'(fault), 32'd0);
    check_eq("rst rom_addr", 32'(rom_addr), 32'd0);

    // 1: sequential fetch, first valid one cycle after run
    rst_n = 1'b1;
    run   = 1'b1;
    instr_ready = 1'b1;
    #1;
    check_eq("t1 pre-valid", 32'(instr_valid), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check_held("t1 seq", 8'(i), plain(8'(i)));
      step();
    end

    // 2: backpressure at 0x02
    apply_reset();
    launch();
    step();
    step();
    check_held("t2 at2", 8'h02, plain(8'h02));
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_held("t2 stall", 8'h02, plain(8'h02));
    end
    instr_ready = 1'b1;
    step();
    check_held("t2 after", 8'h03, plain(8'h03));

    // 3: CALL / RET
    apply_reset();
    rom[8'h00] = enc_brz(8'h0F);
    rom[8'h0F] = enc_call(8'h80);
    rom[8'h81] = EncRet;
    z_flag = 1'b1;
    launch();
    step();
    check_held("t3 call", 8'h0F, enc_call(8'h80));
    check_eq("t3 ras0", 32'(ras_count), 32'd0);
    step();
    check_held("t3 tgt", 8'h80, plain(8'h80));
    check_eq("t3 ras1", 32'(ras_count), 32'd1);
    step();
    check_held("t3 ret", 8'h81, EncRet);
    check_eq("t3 ras1b", 32'(ras_count), 32'd1);
    step();
    check_held("t3 back", 8'h10, plain(8'h10));
    check_eq("t3 ras0b", 32'(ras_count), 32'd0);

    // 4: BRZ / BRN / JUMPR
    apply_reset();
    rom[8'h00] = enc_brz(8'h40);
    rom[8'h01] = enc_brz(8'h40);
    rom[8'h40] = enc_brn(8'h20);
    rom[8'h41] = enc_brn(8'h20);
    rom[8'h20] = EncJumpr;
    launch();
    step();
    check_held("t4 brz nt", 8'h01, enc_brz(8'h40));
    instr_ready = 1'b0;
    #1;
    check_eq("t4 addr z0", 32'(rom_addr), 32'h02);
    z_flag = 1'b1;
    #1;
    check_eq("t4 addr z1", 32'(rom_addr), 32'h40);
    instr_ready = 1'b1;
    step();
    check_held("t4 brz t", 8'h40, enc_brn(8'h20));
    z_flag = 1'b0;
    step();
    check_held("t4 brn nt", 8'h41, enc_brn(8'h20));
    n_flag = 1'b1;
    step();
    check_held("t4 brn t", 8'h20, EncJumpr);
    n_flag     = 1'b0;
    reg_target = 8'h40;
    step();
    check_held("t4 jumpr", 8'h40, enc_brn(8'h20));

    // 5a: RAS overflow on the fifth nested CALL
    apply_reset();
    rom[8'h00] = enc_call(8'h10);
    rom[8'h10] = enc_call(8'h20);
    rom[8'h20] = enc_call(8'h30);
    rom[8'h30] = enc_call(8'h40);
    rom[8'h40] = enc_call(8'h50);
    launch();
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("t5 depth", 32'(ras_count), 32'(i));
    end
    check_held("t5 fifth", 8'h40, enc_call(8'h50));
    check_eq("t5 pre-fault", 32'(fault), 32'd0);
    step();
    check_eq("t5 fault", 32'(fault), 32'd1);
    check_eq("t5 valid", 32'(instr_valid), 32'd0);
    check_eq("t5 ras", 32'(ras_count), 32'd4);
    check_eq("t5 addr", 32'(rom_addr), 32'h40);
    step();
    check_eq("t5 sticky", 32'(fault), 32'd1);

    // 5b: RET on an empty stack
    apply_reset();
    check_eq("t5 rst fault", 32'(fault), 32'd0);
    rom[8'h00] = EncRet;
    launch();
    check_held("t5 ret", 8'h00, EncRet);
    step();
    check_eq("t5u fault", 32'(fault), 32'd1);
    check_eq("t5u valid", 32'(instr_valid), 32'd0);
    check_eq("t5u ras", 32'(ras_count), 32'd0);

    // 6: PC wrap, then asynchronous reset mid-stream
    apply_reset();
    rom[8'h00] = enc_brz(8'hFF);
    z_flag = 1'b1;
    launch();
    step();
    check_held("t6 ff", 8'hFF, plain(8'hFF));
    step();
    check_held("t6 wrap", 8'h00, enc_brz(8'hFF));
    step();
    check_held("t6 ff2", 8'hFF, plain(8'hFF));
    rst_n = 1'b0;
    #1;
    check_eq("t6 rst valid", 32'(instr_valid), 32'd0);
    check_eq("t6 rst instr", 32'(instr), 32'd0);
    check_eq("t6 rst pc", 32'(instr_pc), 32'd0);
    check_eq("t6 rst addr", 32'(rom_addr), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_held("t6 refetch", 8'h00, enc_brz(8'hFF));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
